// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage load/store unit: op codes, FSM states,
// byte-enable constants and lane helpers used by both the top and load_lane_ext.
package mem_access_unit_pkg;

    typedef enum logic [2:0] {
        OP_LW  = 3'd0,
        OP_LH  = 3'd1,
        OP_LHU = 3'd2,
        OP_LB  = 3'd3,
        OP_LBU = 3'd4,
        OP_SW  = 3'd5,
        OP_SH  = 3'd6,
        OP_SB  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    localparam logic [3:0] BE_WORD = 4'b1111;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_BYTE = 4'b0001;

    function automatic logic is_store(op_e op);
        return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
    endfunction

    function automatic logic is_word(op_e op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

    function automatic logic is_half(op_e op);
        return (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
    endfunction

    function automatic logic misaligned(op_e op, logic [1:0] a);
        if (is_word(op)) return a != 2'b00;
        if (is_half(op)) return a[0];
        return 1'b0;
    endfunction

    // Lane actually used: low bits below the access size are dropped.
    function automatic logic [1:0] eff_lane(op_e op, logic [1:0] a);
        if (is_word(op)) return 2'b00;
        if (is_half(op)) return {a[1], 1'b0};
        return a;
    endfunction

    function automatic logic [3:0] lane_be(op_e op, logic [1:0] lane);
        if (is_word(op)) return BE_WORD;
        if (is_half(op)) return BE_HALF << lane;
        return BE_BYTE << lane;
    endfunction

    function automatic logic [31:0] lane_data(op_e op, logic [31:0] w);
        if (is_word(op)) return w;
        if (is_half(op)) return {2{w[15:0]}};
        return {4{w[7:0]}};
    endfunction

endpackage

// File: rtl/mem_access_unit_load_lane_ext.sv
// Picks the addressed byte/half lane out of a returned word and sign- or
// zero-extends it to 32 bits according to the load op.
module load_lane_ext
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  op,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (addr)
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            2'd3:    byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        data = rdata;
        case (op_e'(op))
            OP_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  data = {24'h0, byte_sel};
            OP_LH:   data = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  data = {16'h0, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: one outstanding request, byte-lane store packing,
// lane-extracting loads and a wait timeout. Define MISALIGN_TRAP_EN to trap
// misaligned half/word accesses instead of silently aligning them.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int MEM_LAT_MAX = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [4:0]        req_rd,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_data,
    output logic [4:0]        rsp_rd,
    output logic              rsp_err
);

    localparam int CNT_W = $clog2(MEM_LAT_MAX + 1);

    state_e            state_q, state_d;
    op_e               op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        lane_q;
    logic [3:0]        be_q;
    logic [31:0]       wd_q;
    logic [4:0]        rd_q;
    logic [31:0]       data_q;
    logic              err_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [31:0]       ext_data;
    logic              trap, accept, capture, timeout;
    op_e               op_in;
    logic [1:0]        lane_in;

    assign op_in   = op_e'(req_op);
    assign lane_in = eff_lane(op_in, req_addr[1:0]);

`ifdef MISALIGN_TRAP_EN
    assign trap = misaligned(op_in, req_addr[1:0]);
`else
    assign trap = 1'b0;
`endif

    load_lane_ext u_ext (
        .rdata (mem_rdata),
        .addr  (lane_q),
        .op    (op_q),
        .data  (ext_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        capture = 1'b0;
        timeout = 1'b0;
        case (state_q)
            S_IDLE: if (req_valid) begin
                accept  = 1'b1;
                state_d = trap ? S_RESP : S_ISSUE;
            end
            S_ISSUE: if (mem_ready) state_d = is_store(op_q) ? S_RESP : S_WAIT;
            S_WAIT: begin
                // Data arriving on the limit cycle still counts as a hit.
                if (mem_rvalid) begin
                    capture = 1'b1;
                    state_d = S_RESP;
                end else if (cnt_q == CNT_W'(MEM_LAT_MAX - 1)) begin
                    timeout = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q   <= OP_LW;
            addr_q <= '0;
            lane_q <= 2'b00;
            be_q   <= 4'b0000;
            wd_q   <= 32'h0;
            rd_q   <= 5'd0;
            data_q <= 32'h0;
            err_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            if (accept) begin
                op_q   <= op_in;
                addr_q <= {req_addr[ADDR_W-1:2], 2'b00};
                lane_q <= lane_in;
                be_q   <= lane_be(op_in, lane_in);
                wd_q   <= lane_data(op_in, req_wdata);
                rd_q   <= req_rd;
                data_q <= 32'h0;
                err_q  <= trap;
                cnt_q  <= '0;
            end
            if (state_q == S_WAIT) cnt_q <= cnt_q + CNT_W'(1);
            if (capture) begin
                data_q <= ext_data;
                err_q  <= 1'b0;
            end
            if (timeout) begin
                data_q <= 32'h0;
                err_q  <= 1'b1;
            end
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign mem_valid = (state_q == S_ISSUE);
    assign mem_we    = (state_q == S_ISSUE) && is_store(op_q);
    assign mem_addr  = addr_q;
    assign mem_be    = be_q;
    assign mem_wdata = wd_q;
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_data  = data_q;
    assign rsp_rd    = rd_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus randomized ops
// compared against an arithmetic reference model of lane selection/extension.
module tb_mem_access_unit;

    localparam int LAT = 15;
    localparam logic [2:0] LW = 3'd0, LH = 3'd1, LHU = 3'd2, LB = 3'd3,
                           LBU = 3'd4, SW = 3'd5, SH = 3'd6, SB = 3'd7;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = 3'd0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [4:0]  req_rd = 5'd0;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_rd;
    logic        rsp_err;

    int tests = 0;
    int fails = 0;

    // Observations of the most recent run_op call.
    int          r_lat, r_mv;
    logic [31:0] r_data, r_addr, r_wd;
    logic [4:0]  r_rd;
    logic [3:0]  r_be;
    logic        r_err, r_we, r_stable, r_post_valid, r_post_ready, r_resp_ready;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(32), .MEM_LAT_MAX(LAT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_rd(rsp_rd), .rsp_err(rsp_err)
    );

    function automatic bit trap_on();
`ifdef MISALIGN_TRAP_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    // Reference model from the architectural rules, using plain arithmetic.
    function automatic void model(input logic [2:0] op, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [31:0] rdata,
                                  output logic [3:0] be, output logic [31:0] wd,
                                  output logic [31:0] waddr, output logic [31:0] data,
                                  output bit trap);
        int lane, size, alane;
        longint unsigned span, raw;
        lane  = int'(addr % 4);
        size  = (op == LW || op == SW) ? 4 : (op == LH || op == LHU || op == SH) ? 2 : 1;
        trap  = trap_on() && (lane % size) != 0;
        alane = lane - (lane % size);
        span  = longint'(1) << (8 * size);
        be    = 4'(((1 << size) - 1) << alane);
        waddr = addr - 32'(lane);
        wd    = (size == 4) ? wdata : 32'((wdata % span) * ((size == 2) ? 32'h0001_0001 : 32'h0101_0101));
        raw   = (longint'(rdata) / (longint'(1) << (8 * alane))) % span;
        data  = 32'(raw);
        if ((op == LB || op == LH) && raw >= span / 2) data = 32'(raw) - 32'(span);
        if (op >= SW || trap) data = 32'h0;
    endfunction

    // Plays the memory side for one op and records what the DUT did.
    task automatic run_op(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [4:0] rd, input int rdy_wait, input int rv_wait,
                          input logic [31:0] rdata);
        int waited, hs;
        bit done;
        waited = 0; hs = 0; done = 0; r_mv = 0; r_stable = 1'b1; r_lat = 1;
        r_be = 4'h0; r_addr = 32'h0; r_wd = 32'h0; r_we = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata; req_rd = rd;
        for (int c = 0; c < 200 && !done; c++) begin
            if (c > 0) req_valid = 1'b0;
            if (c > 0 && rsp_valid) begin
                r_data = rsp_data; r_err = rsp_err; r_rd = rsp_rd; r_resp_ready = req_ready;
                done = 1;
            end else begin
                mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
                if (mem_valid) begin
                    if (r_mv == 0) begin
                        r_be = mem_be; r_addr = mem_addr; r_wd = mem_wdata; r_we = mem_we;
                    end else if (mem_be !== r_be || mem_addr !== r_addr ||
                                 mem_wdata !== r_wd || mem_we !== r_we) begin
                        r_stable = 1'b0;
                    end
                    r_mv++;
                    if (waited >= rdy_wait) begin
                        mem_ready = 1'b1; hs = r_lat;
                    end else waited++;
                end
                if (hs > 0 && r_lat > hs && rv_wait >= 0 && r_lat - hs == rv_wait) begin
                    mem_rvalid = 1'b1; mem_rdata = rdata;
                end
                @(posedge clk);
                @(negedge clk);
                r_lat++;
            end
        end
        mem_ready = 1'b0; mem_rvalid = 1'b0; req_valid = 1'b0;
        if (!done) begin
            tests++; fails++;
            $display("FAIL run_op_bound: no rsp_valid within 200 cycles for op %0d addr %h", op, addr);
        end
        @(negedge clk);
        r_post_valid = rsp_valid; r_post_ready = req_ready;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if ({req_ready, mem_valid, mem_we, rsp_valid, rsp_err} !== 5'b10000 ||
            mem_addr !== 32'h0 || mem_be !== 4'h0 || mem_wdata !== 32'h0 ||
            rsp_data !== 32'h0 || rsp_rd !== 5'd0) begin
            fails++;
            $display("FAIL reset_state: ready=%b mval=%b we=%b rval=%b err=%b addr=%h be=%b, required ready=1 rest 0",
                     req_ready, mem_valid, mem_we, rsp_valid, rsp_err, mem_addr, mem_be);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_load_byte();
        run_op(LB, 32'h1003, 32'h0, 5'd3, 0, 1, 32'h80FF7F01);
        tests++;
        if (r_data !== 32'hFFFFFF80 || r_err !== 1'b0 || r_rd !== 5'd3) begin
            fails++; $display("FAIL lb_1003: data=%h err=%b rd=%0d, required FFFFFF80 0 3", r_data, r_err, r_rd);
        end
        tests++;
        if (r_lat !== 4 || r_mv !== 1 || r_we !== 1'b0 || r_be !== 4'b1000 || r_addr !== 32'h1000) begin
            fails++; $display("FAIL lb_latency_port: lat=%0d mv=%0d we=%b be=%b addr=%h, required 4 1 0 1000 00001000",
                              r_lat, r_mv, r_we, r_be, r_addr);
        end
        tests++;
        if (r_resp_ready !== 1'b0 || r_post_valid !== 1'b0 || r_post_ready !== 1'b1) begin
            fails++; $display("FAIL resp_pulse: ready_in_resp=%b valid_after=%b ready_after=%b, required 0 0 1",
                              r_resp_ready, r_post_valid, r_post_ready);
        end
        run_op(LBU, 32'h1003, 32'h0, 5'd4, 0, 1, 32'h80FF7F01);
        tests++;
        if (r_data !== 32'h00000080) begin
            fails++; $display("FAIL lbu_1003: data=%h, required 00000080", r_data);
        end
        run_op(LB, 32'h1000, 32'h0, 5'd5, 0, 1, 32'h80FF7F01);
        tests++;
        if (r_data !== 32'h00000001) begin
            fails++; $display("FAIL lb_1000: data=%h, required 00000001", r_data);
        end
    endtask

    task automatic test_load_half();
        run_op(LH, 32'h1002, 32'h0, 5'd6, 0, 1, 32'h80FF7F01);
        tests++;
        if (r_data !== 32'hFFFF80FF || r_be !== 4'b1100) begin
            fails++; $display("FAIL lh_1002: data=%h be=%b, required FFFF80FF 1100", r_data, r_be);
        end
        run_op(LHU, 32'h1002, 32'h0, 5'd7, 0, 1, 32'h80FF7F01);
        tests++;
        if (r_data !== 32'h000080FF) begin
            fails++; $display("FAIL lhu_1002: data=%h, required 000080FF", r_data);
        end
    endtask

    task automatic test_store_byte();
        run_op(SB, 32'h2001, 32'h12345678, 5'd9, 0, -1, 32'h0);
        tests++;
        if (r_be !== 4'b0010 || r_wd !== 32'h78787878 || r_addr !== 32'h2000 || r_we !== 1'b1) begin
            fails++; $display("FAIL sb_port: be=%b wd=%h addr=%h we=%b, required 0010 78787878 00002000 1",
                              r_be, r_wd, r_addr, r_we);
        end
        tests++;
        if (r_lat !== 3 || r_data !== 32'h0 || r_err !== 1'b0 || r_rd !== 5'd9) begin
            fails++; $display("FAIL sb_resp: lat=%0d data=%h err=%b rd=%0d, required 3 0 0 9", r_lat, r_data, r_err, r_rd);
        end
    endtask

    task automatic test_backpressure();
        run_op(SH, 32'h3002, 32'hABCD1234, 5'd11, 5, -1, 32'h0);
        tests++;
        if (r_stable !== 1'b1 || r_mv !== 6 || r_be !== 4'b1100 || r_wd !== 32'h12341234 || r_addr !== 32'h3000) begin
            fails++; $display("FAIL sh_backpressure: stable=%b mv_cycles=%0d be=%b wd=%h addr=%h, required 1 6 1100 12341234 00003000",
                              r_stable, r_mv, r_be, r_wd, r_addr);
        end
        tests++;
        if (r_lat !== 8 || r_post_valid !== 1'b0 || r_err !== 1'b0) begin
            fails++; $display("FAIL sh_single_rsp: lat=%0d valid_after=%b err=%b, required 8 0 0", r_lat, r_post_valid, r_err);
        end
    endtask

    task automatic test_timeout();
        run_op(LW, 32'h5000, 32'h0, 5'd12, 0, -1, 32'h0);
        tests++;
        if (r_err !== 1'b1 || r_data !== 32'h0 || r_lat !== LAT + 3) begin
            fails++; $display("FAIL timeout: err=%b data=%h lat=%0d, required 1 0 %0d", r_err, r_data, r_lat, LAT + 3);
        end
        run_op(LW, 32'h5004, 32'h0, 5'd13, 0, LAT, 32'h13572468);
        tests++;
        if (r_err !== 1'b0 || r_data !== 32'h13572468 || r_lat !== LAT + 3) begin
            fails++; $display("FAIL limit_data_wins: err=%b data=%h lat=%0d, required 0 13572468 %0d", r_err, r_data, r_lat, LAT + 3);
        end
    endtask

    task automatic test_misalign();
        run_op(LW, 32'h4002, 32'h0, 5'd14, 0, 1, 32'hCAFEBABE);
        tests++;
        if (trap_on()) begin
            if (r_err !== 1'b1 || r_data !== 32'h0 || r_mv !== 0 || r_lat !== 2) begin
                fails++; $display("FAIL misalign_trap: err=%b data=%h mv_cycles=%0d lat=%0d, required 1 0 0 2",
                                  r_err, r_data, r_mv, r_lat);
            end
        end else begin
            if (r_err !== 1'b0 || r_data !== 32'hCAFEBABE || r_addr !== 32'h4000 || r_be !== 4'b1111) begin
                fails++; $display("FAIL misalign_aligned: err=%b data=%h addr=%h be=%b, required 0 CAFEBABE 00004000 1111",
                                  r_err, r_data, r_addr, r_be);
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        int seen;
        seen = 0;
        @(negedge clk);
        req_valid = 1'b1; req_op = LW; req_addr = 32'h6000; req_rd = 5'd15; mem_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        mem_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        tests++;
        if (req_ready !== 1'b1 || mem_valid !== 1'b0 || rsp_valid !== 1'b0) begin
            fails++; $display("FAIL reset_mid_wait: ready=%b mval=%b rval=%b, required 1 0 0", req_ready, mem_valid, rsp_valid);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (LAT + 4) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        tests++;
        if (seen !== 0 || req_ready !== 1'b1) begin
            fails++; $display("FAIL reset_no_rsp: rsp_pulses=%0d ready=%b, required 0 1", seen, req_ready);
        end
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] addr, wdata, rdata, e_wd, e_addr, e_data;
        logic [3:0]  e_be;
        logic [4:0]  rd;
        bit          e_trap;
        int          rdy, rv, e_lat;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7)); addr = $urandom; wdata = $urandom; rdata = $urandom;
            rd = 5'($urandom); rdy = $urandom_range(0, 3); rv = $urandom_range(1, 4);
            model(op, addr, wdata, rdata, e_be, e_wd, e_addr, e_data, e_trap);
            e_lat = e_trap ? 2 : (op >= SW) ? 3 + rdy : 3 + rdy + rv;
            run_op(op, addr, wdata, rd, rdy, rv, rdata);
            tests++;
            if (r_data !== e_data || r_err !== 1'(e_trap) || r_rd !== rd || r_lat !== e_lat) begin
                fails++; $display("FAIL rand_rsp[%0d] op=%0d addr=%h: data=%h err=%b rd=%0d lat=%0d, required %h %b %0d %0d",
                                  i, op, addr, r_data, r_err, r_rd, r_lat, e_data, e_trap, rd, e_lat);
            end
            tests++;
            if (e_trap ? (r_mv !== 0) :
                (r_be !== e_be || r_addr !== e_addr || r_we !== (op >= SW) || (op >= SW && r_wd !== e_wd))) begin
                fails++; $display("FAIL rand_port[%0d] op=%0d addr=%h: mv=%0d be=%b maddr=%h we=%b wd=%h, required be=%b maddr=%h wd=%h trap=%b",
                                  i, op, addr, r_mv, r_be, r_addr, r_we, r_wd, e_be, e_addr, e_wd, e_trap);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_byte();
        test_load_half();
        test_store_byte();
        test_backpressure();
        test_timeout();
        test_misalign();
        test_reset_mid_wait();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage load/store engine for the pipelined MIPS core.
- Store path narrows 32-bit register data into byte lanes plus byte enables. Load path picks the addressed lane from the returned word and zero- or sign-extends it to 32 bits.
- Sits between the EX/MEM pipeline register and the data memory port.
- Holds one outstanding request, with valid/ready handshakes on both sides.

Parameters:
- ADDR_W, 32, byte-address width.
- MEM_LAT_MAX, 15, maximum memory wait cycles before the timeout error; counter width is clog2(MEM_LAT_MAX+1).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  pipeline presents a memory op.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_op  in  3  LW=0, LH=1, LHU=2, LB=3, LBU=4, SW=5, SH=6, SB=7.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, low-aligned.
- req_rd  in  5  destination register tag, returned with the response.
- mem_valid  out  1  request to data memory.
- mem_ready  in  1  memory accepts the request.
- mem_we  out  1  write request.
- mem_addr  out  ADDR_W  word-aligned address (bits [1:0] = 0).
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-replicated store data.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  32  read word.
- rsp_valid  out  1  one-cycle pulse when the op completes.
- rsp_data  out  32  extended load data; 0 for stores.
- rsp_rd  out  5  tag of the completed op.
- rsp_err  out  1  misalignment or timeout, valid with rsp_valid.

Behaviour:
- States: IDLE, ISSUE, WAIT, RESP.
- Reset: state IDLE. All outputs 0 except req_ready=1. Counter 0. Reset asserted mid-operation abandons the op with no response.
- IDLE:
  - On req_valid, latch op, addr, wdata and rd.
  - If misaligned (see optional feature), go to RESP with err=1.
  - Otherwise go to ISSUE.
- ISSUE:
  - mem_valid=1 with registered addr, be and wdata; hold them stable until mem_ready.
  - On handshake, a store goes to RESP and a load goes to WAIT.
- WAIT:
  - The counter increments each cycle.
  - On mem_rvalid, register the extended data and go to RESP.
  - If the counter reaches MEM_LAT_MAX without mem_rvalid, go to RESP with err=1 and data=0.
  - If mem_rvalid and the limit coincide, the data wins and err=0.
- RESP:
  - rsp_valid=1 for exactly one cycle, then IDLE.
  - req_ready=1 again the following cycle.
- Latency: store, 3 cycles from request to rsp_valid with zero-wait memory. Load, 4 cycles when mem_rvalid follows the handshake by 1 cycle.
- Byte enables from addr[1:0]:
  - SW gives 1111.
  - SH gives 0011 (a1=0) or 1100 (a1=1).
  - SB gives 0001 << addr[1:0].
- Store data replication: SH gives {2{wdata[15:0]}}; SB gives {4{wdata[7:0]}}.
- Load extraction uses the same lane select:
  - LB and LH sign-extend from the lane MSB.
  - LBU and LHU zero-extend.
  - LW passes the word through.
- Requests are ignored outside IDLE; upstream must hold them.

Optional Feature:
- Macro MISALIGN_TRAP_EN.
- Defined: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, skips memory entirely and returns rsp_err=1 and rsp_data=0 two cycles after acceptance.
- Undefined: misaligned low bits are silently cleared and the access proceeds as aligned; rsp_err is asserted only on timeout.

Decomposition:
- Shared define header: op codes LW..SB, FSM state encodings, byte-enable constants.
- One combinational sub-module, load_lane_ext: inputs rdata, addr[1:0] and op; output the extended 32-bit value. It is instantiated once, in the WAIT capture path.

Test Plan:
- Load/byte: mem word 0x80FF7F01. LB at addr 0x1003 gives 0xFFFFFF80; LBU at 0x1003 gives 0x00000080; LB at 0x1000 gives 0x00000001.
- Load/half: same word. LH at 0x1002 gives 0xFFFF80FF; LHU at 0x1002 gives 0x000080FF.
- Store/byte: SB at addr 0x2001 with wdata 0x12345678 gives mem_be=0010, mem_wdata=0x78787878, mem_addr=0x2000, and rsp_valid 3 cycles after acceptance when mem_ready is tied high.
- Backpressure: mem_ready held low for 5 cycles on an SH to 0x3002. mem_valid, mem_addr, be=1100 and wdata stay stable throughout; exactly one rsp_valid follows.
- Timeout: LW with mem_rvalid never asserted gives rsp_err=1 and rsp_data=0 after MEM_LAT_MAX wait cycles. A second run asserts mem_rvalid on the limit cycle and gives err=0.
- Misalignment and reset: LW at 0x4002 gives err=1 with no mem_valid when MISALIGN_TRAP_EN is defined, or an aligned read of 0x4000 when undefined. Separately, reset pulsed during WAIT returns the unit to IDLE with no rsp_valid.
